// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with optional two-entry skid buffer.
// SKID=1 decouples in_ready from out_ready; SKID=0 is a single-entry stall stage.
module pipe_stage_skid #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic              w_in_ready;
  logic              w_in_xfer;

  generate
    if (SKID != 0) begin : g_skid
      // Pure state decode: no combinational path from out_ready.
      assign w_in_ready = (r_state != ST_TWO);
    end else begin : g_stall
      assign w_in_ready = (r_state == ST_EMPTY) || out_ready;
    end
  endgenerate

  assign w_in_xfer = in_valid && w_in_ready;

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign occupancy = r_state;
  // Bubbles must never carry enables downstream.
  assign out_ctrl  = out_valid ? r_main_ctrl : '0;
  assign out_data  = r_main_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && out_ready) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
          end else if (w_in_xfer && SKID != 0) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
            r_state     <= ST_TWO;
          end else if (out_ready) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
            r_state     <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule
